vec_elementwise_engine: RTL and testbench

- Parametrised successor to the current single-lane Hadamard engine.
- Streams two operand vectors from BRAM ports A and B. Applies a run-time selected element-wise op (mul/add/sub/max) across P packed lanes through a fixed-latency pipeline. Writes results to the product BRAM.
- Software-programmable length. Start/done/acknowledge handshake via ps_control/pl_status, plus a length-error report.

---
 rtl/vec_elementwise_engine_pkg.sv | 48 ++++
 rtl/vec_elementwise_engine_lane_alu.sv | 53 +++++
 rtl/vec_elementwise_engine.sv | 221 ++++++++++++++++++++++
 tb/tb_vec_elementwise_engine.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_elementwise_engine_pkg.sv
// Shared definitions for the element-wise vector engine.
//   op_e      : run-time selectable lane operation
//   state_e   : controller states
//   CTRL_* / STAT_* : bit positions inside ps_control / pl_status
//   sat_inc   : saturating increment used by the words-written counter
package vec_pkg;

    typedef enum logic [1:0] {
        OP_MUL = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2,
        OP_MAX = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_OP_LSB    = 1;
    localparam int CTRL_OP_MSB    = 2;
    localparam int CTRL_LEN_LSB   = 16;
    localparam int CTRL_LEN_MSB   = 31;

    localparam int STAT_DONE_BIT  = 0;
    localparam int STAT_BUSY_BIT  = 1;
    localparam int STAT_ERR_BIT   = 2;
    localparam int STAT_CNT_LSB   = 16;
    localparam int STAT_CNT_MSB   = 31;

    localparam int CNT_W = 16;

    // Increment that sticks at lim instead of wrapping past it.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] lim);
        logic [CNT_W-1:0] r;
        if (v >= lim) begin
            r = lim;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/vec_elementwise_engine_lane_alu.sv
// One arithmetic lane of the element-wise engine.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   op_i          : operation (mul/add/sub/max)
//   a_i, b_i      : two's-complement operands
//   res_o         : result, valid LAT cycles after the operands
module vec_lane_alu
    import vec_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int LAT        = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  op_e                   op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH-1:0] res_o
);

    logic [DATA_WIDTH-1:0] res_s;
    logic [DATA_WIDTH-1:0] pipe_q [LAT];

    // Combinational lane operation; every result wraps to DATA_WIDTH bits.
    always_comb begin
        res_s = {DATA_WIDTH{1'b0}};
        case (op_i)
            // The low half of a signed product equals the low half of the
            // unsigned product, so a same-width multiply gives the wrapped value.
            OP_MUL:  res_s = a_i * b_i;
            OP_ADD:  res_s = a_i + b_i;
            OP_SUB:  res_s = a_i - b_i;
            OP_MAX:  res_s = ($signed(a_i) > $signed(b_i)) ? a_i : b_i;
            default: res_s = {DATA_WIDTH{1'b0}};
        endcase
    end

    // Result pipeline of LAT register stages.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_q[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            pipe_q[0] <= res_s;
            for (int i = 1; i < LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign res_o = pipe_q[LAT-1];

endmodule

// File: rtl/vec_elementwise_engine.sv
// Element-wise vector engine: streams operand words from BRAM ports A and B,
// applies one op across P packed lanes, and writes results to the product BRAM.
//   clk, reset                 : clock, asynchronous active-low reset
//   ps_control                 : [0] start, [2:1] op, [31:16] length in words
//   pl_status                  : [0] done, [1] busy, [2] len_err, [31:16] words written
//   bram_*_a / bram_*_b        : read-only operand ports (write side tied off)
//   bram_*_product             : result write port (read data ignored)
module vec_elementwise_engine
    import vec_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int P          = 2,
    parameter int BRAM_WIDTH = 32,
    parameter int WORD_BYTES = 4,
    parameter int ADDR_WIDTH = 12,
    parameter int NUM_WORDS  = 512,
    parameter int LAT        = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           ps_control,
    output logic [31:0]           pl_status,
    output logic [ADDR_WIDTH-1:0] bram_addr_a,
    input  logic [BRAM_WIDTH-1:0] bram_rddata_a,
    output logic [BRAM_WIDTH-1:0] bram_wrdata_a,
    output logic [WORD_BYTES-1:0] bram_we_a,
    output logic [ADDR_WIDTH-1:0] bram_addr_b,
    input  logic [BRAM_WIDTH-1:0] bram_rddata_b,
    output logic [BRAM_WIDTH-1:0] bram_wrdata_b,
    output logic [WORD_BYTES-1:0] bram_we_b,
    output logic [ADDR_WIDTH-1:0] bram_addr_product,
    input  logic [BRAM_WIDTH-1:0] bram_rddata_product,
    output logic [BRAM_WIDTH-1:0] bram_wrdata_product,
    output logic [WORD_BYTES-1:0] bram_we_product
);

    if (BRAM_WIDTH != P * DATA_WIDTH) begin : g_bad_width
        $error("BRAM_WIDTH must equal P*DATA_WIDTH");
    end
    if ((NUM_WORDS - 1) * WORD_BYTES >= (1 << ADDR_WIDTH)) begin : g_bad_addr
        $error("ADDR_WIDTH too narrow for (NUM_WORDS-1)*WORD_BYTES");
    end
    if (LAT < 1) begin : g_bad_lat
        $error("LAT must be at least 1");
    end

    localparam logic [CNT_W-1:0] NUM_WORDS_C = CNT_W'(NUM_WORDS);

    state_e                state_q, state_d;
    op_e                   op_q;
    logic [CNT_W-1:0]      len_q;
    logic [CNT_W-1:0]      rd_idx_q;
    logic [CNT_W-1:0]      words_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic                  len_err_q;
    logic [LAT:0]          vld_q;
    logic [ADDR_WIDTH-1:0] waddr_q [LAT+1];
    logic [BRAM_WIDTH-1:0] res_s;

    logic                  start_s;
    op_e                   op_in_s;
    logic [CNT_W-1:0]      len_in_s;
    logic                  len_ok_s;
    logic                  accept_s;
    logic                  last_issue_s;
    logic                  issue_s;
    logic                  busy_s;
    logic                  done_s;
    logic                  unused_ok_s;

    assign start_s      = ps_control[CTRL_START_BIT];
    assign op_in_s      = op_e'(ps_control[CTRL_OP_MSB:CTRL_OP_LSB]);
    assign len_in_s     = ps_control[CTRL_LEN_MSB:CTRL_LEN_LSB];
    assign len_ok_s     = (len_in_s != 16'd0) && (len_in_s <= NUM_WORDS_C);
    assign accept_s     = (state_q == IDLE) && start_s;
    assign last_issue_s = (rd_idx_q == (len_q - 16'd1));

    // Controller state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Controller next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_s) begin
                    state_d = len_ok_s ? RUN : DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (last_issue_s) begin
                    state_d = DRAIN;
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                // Leave only after the last result has been written.
                if (vld_q == {(LAT+1){1'b0}}) begin
                    state_d = DONE;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                if (!start_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller state decode.
    always_comb begin
        issue_s = 1'b0;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        case (state_q)
            IDLE:    begin issue_s = 1'b0; busy_s = 1'b0; done_s = 1'b0; end
            RUN:     begin issue_s = 1'b1; busy_s = 1'b1; done_s = 1'b0; end
            DRAIN:   begin issue_s = 1'b0; busy_s = 1'b1; done_s = 1'b0; end
            DONE:    begin issue_s = 1'b0; busy_s = 1'b0; done_s = 1'b1; end
            default: begin issue_s = 1'b0; busy_s = 1'b0; done_s = 1'b0; end
        endcase
    end

    // Latched job parameters, read index/address and length-error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q      <= OP_MUL;
            len_q     <= 16'd0;
            len_err_q <= 1'b0;
            rd_idx_q  <= 16'd0;
            rd_addr_q <= {ADDR_WIDTH{1'b0}};
        end else if (accept_s) begin
            op_q      <= op_in_s;
            len_q     <= len_in_s;
            len_err_q <= !len_ok_s;
            rd_idx_q  <= 16'd0;
            rd_addr_q <= {ADDR_WIDTH{1'b0}};
        end else if (issue_s) begin
            rd_idx_q  <= rd_idx_q + 16'd1;
            rd_addr_q <= rd_addr_q + ADDR_WIDTH'(WORD_BYTES);
        end else if ((state_q == DONE) && !start_s) begin
            len_err_q <= 1'b0;
        end else begin
            len_err_q <= len_err_q;
        end
    end

    // Words-written counter: cleared on a new job, held afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            words_q <= 16'd0;
        end else if (accept_s) begin
            words_q <= 16'd0;
        end else if (vld_q[LAT]) begin
            words_q <= sat_inc(words_q, NUM_WORDS_C);
        end else begin
            words_q <= words_q;
        end
    end

    // Valid/address delay line: stage 0 lines up with BRAM read data, stage
    // LAT lines up with the lane ALU outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q <= {(LAT+1){1'b0}};
            for (int i = 0; i <= LAT; i++) begin
                waddr_q[i] <= {ADDR_WIDTH{1'b0}};
            end
        end else begin
            vld_q      <= {vld_q[LAT-1:0], issue_s};
            waddr_q[0] <= rd_addr_q;
            for (int i = 1; i <= LAT; i++) begin
                waddr_q[i] <= waddr_q[i-1];
            end
        end
    end

    for (genvar k = 0; k < P; k++) begin : g_lane
        vec_lane_alu #(
            .DATA_WIDTH (DATA_WIDTH),
            .LAT        (LAT)
        ) u_alu (
            .clk_i  (clk),
            .rst_ni (reset),
            .op_i   (op_q),
            .a_i    (bram_rddata_a[k*DATA_WIDTH +: DATA_WIDTH]),
            .b_i    (bram_rddata_b[k*DATA_WIDTH +: DATA_WIDTH]),
            .res_o  (res_s[k*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    assign bram_addr_a         = rd_addr_q;
    assign bram_addr_b         = rd_addr_q;
    assign bram_wrdata_a       = {BRAM_WIDTH{1'b0}};
    assign bram_wrdata_b       = {BRAM_WIDTH{1'b0}};
    assign bram_we_a           = {WORD_BYTES{1'b0}};
    assign bram_we_b           = {WORD_BYTES{1'b0}};
    assign bram_addr_product   = waddr_q[LAT];
    assign bram_wrdata_product = res_s;
    assign bram_we_product     = vld_q[LAT] ? {WORD_BYTES{1'b1}} : {WORD_BYTES{1'b0}};

    assign pl_status = {words_q, 13'd0, len_err_q, busy_s, done_s};

    // Product read data and the reserved control bits carry no function.
    assign unused_ok_s = ^{bram_rddata_product, ps_control[15:3]};

endmodule

// File: tb/tb_vec_elementwise_engine.sv
module tb_vec_elementwise_engine;

    localparam int DW  = 16;
    localparam int P   = 2;
    localparam int BW  = 32;
    localparam int WB  = 4;
    localparam int AW  = 12;
    localparam int NW  = 512;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   ps_control;
    logic [31:0]   pl_status;
    logic [AW-1:0] bram_addr_a, bram_addr_b, bram_addr_product;
    logic [BW-1:0] bram_rddata_a, bram_rddata_b;
    logic [BW-1:0] bram_wrdata_a, bram_wrdata_b, bram_wrdata_product;
    logic [WB-1:0] bram_we_a, bram_we_b, bram_we_product;
    logic [BW-1:0] bram_rddata_product;

    logic [31:0]   mem_a [NW];
    logic [31:0]   mem_b [NW];
    logic [31:0]   mem_p [NW];
    int            we_total = 0;
    logic [AW-1:0] last_wr_addr = '0;

    int n_checks = 0;
    int n_fails  = 0;
    int lat_meas;
    bit timed_out;
    int we_snap;

    always #5 clk = ~clk;

    assign bram_rddata_product = 32'h0;

    vec_elementwise_engine #(
        .DATA_WIDTH(DW), .P(P), .BRAM_WIDTH(BW), .WORD_BYTES(WB),
        .ADDR_WIDTH(AW), .NUM_WORDS(NW), .LAT(LAT)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .ps_control          (ps_control),
        .pl_status           (pl_status),
        .bram_addr_a         (bram_addr_a),
        .bram_rddata_a       (bram_rddata_a),
        .bram_wrdata_a       (bram_wrdata_a),
        .bram_we_a           (bram_we_a),
        .bram_addr_b         (bram_addr_b),
        .bram_rddata_b       (bram_rddata_b),
        .bram_wrdata_b       (bram_wrdata_b),
        .bram_we_b           (bram_we_b),
        .bram_addr_product   (bram_addr_product),
        .bram_rddata_product (bram_rddata_product),
        .bram_wrdata_product (bram_wrdata_product),
        .bram_we_product     (bram_we_product)
    );

    // BRAM models: one-cycle read latency, product write on we.
    always @(posedge clk) begin
        bram_rddata_a <= mem_a[bram_addr_a[10:2]];
        bram_rddata_b <= mem_b[bram_addr_b[10:2]];
        if (bram_we_product != 4'h0) begin
            mem_p[bram_addr_product[10:2]] <= bram_wrdata_product;
            we_total     <= we_total + 1;
            last_wr_addr <= bram_addr_product;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic ctrl(input logic [1:0] op, input logic [15:0] len, input logic start);
        ps_control = {len, 13'd0, op, start};
    endtask

    // Wait for done; measure first-busy to first-write distance.
    task automatic wait_done(input int budget);
        int first_busy, first_we;
        first_busy = -1;
        first_we   = -1;
        timed_out  = 1'b1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (pl_status[1] && first_busy < 0) first_busy = k;
            if (bram_we_product != 4'h0 && first_we < 0) first_we = k;
            if (pl_status[0]) begin
                timed_out = 1'b0;
                break;
            end
        end
        lat_meas = first_we - first_busy;
        check("done_timeout", {31'd0, timed_out}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < NW; i++) begin
            mem_a[i] = 32'h0;
            mem_b[i] = 32'h0;
        end
        reset      = 1'b0;
        ps_control = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_status", pl_status, 32'h0);
        check("rst_we", {28'd0, bram_we_product}, 32'h0);
        check("rst_addr_a", {20'd0, bram_addr_a}, 32'h0);
        check("rst_addr_p", {20'd0, bram_addr_product}, 32'h0);
        check("rst_wrdata", bram_wrdata_product, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        // Basic add, length 4
        for (int i = 0; i < 4; i++) begin
            mem_a[i] = {16'(i + 1), 16'(i)};
            mem_b[i] = {16'd10, 16'd20};
        end
        we_snap = we_total;
        ctrl(2'd1, 16'd4, 1'b1);
        wait_done(100);
        check("add_latency", 32'(lat_meas), 32'(1 + LAT));
        check("add_status", pl_status, 32'h0004_0001);
        check("add_w0", mem_p[0], 32'h000B_0014);
        check("add_w3", mem_p[3], 32'h000E_0017);
        check("add_nwrites", 32'(we_total - we_snap), 32'd4);
        ctrl(2'd1, 16'd4, 1'b0);
        @(negedge clk);
        check("add_done_clr", pl_status, 32'h0004_0000);

        // mul wrap, per-lane distinct operands
        mem_a[0] = {16'h0003, 16'h7FFF};
        mem_b[0] = {16'hFFFE, 16'h0002};
        ctrl(2'd0, 16'd1, 1'b1);
        wait_done(100);
        check("mul_wrap", mem_p[0], 32'hFFFA_FFFE);
        ctrl(2'd0, 16'd1, 1'b0);
        @(negedge clk);

        // sub wrap
        mem_a[0] = {16'h8000, 16'h0005};
        mem_b[0] = {16'h0001, 16'h0007};
        ctrl(2'd2, 16'd1, 1'b1);
        wait_done(100);
        check("sub_wrap", mem_p[0], 32'h7FFF_FFFE);
        ctrl(2'd2, 16'd1, 1'b0);
        @(negedge clk);

        // signed max, lanes with different winners
        mem_a[0] = {16'hFFFF, 16'h0005};
        mem_b[0] = {16'h0001, 16'hFFF9};
        ctrl(2'd3, 16'd1, 1'b1);
        wait_done(100);
        check("max_signed", mem_p[0], 32'h0001_0005);
        ctrl(2'd3, 16'd1, 1'b0);
        @(negedge clk);

        // Full length
        for (int i = 0; i < NW; i++) begin
            mem_a[i] = {16'(i), 16'(i)};
            mem_b[i] = 32'h0001_0001;
        end
        we_snap = we_total;
        ctrl(2'd1, 16'(NW), 1'b1);
        wait_done(1000);
        check("max_len_status", pl_status, 32'h0200_0001);
        check("max_len_lastaddr", {20'd0, last_wr_addr}, 32'((NW - 1) * WB));
        check("max_len_lastdata", mem_p[NW-1], 32'h0200_0200);
        check("max_len_nwrites", 32'(we_total - we_snap), 32'(NW));
        ctrl(2'd1, 16'(NW), 1'b0);
        @(negedge clk);

        // Length errors
        we_snap = we_total;
        ctrl(2'd1, 16'd0, 1'b1);
        wait_done(20);
        check("len0_status", pl_status, 32'h0000_0005);
        ctrl(2'd1, 16'd0, 1'b0);
        @(negedge clk);
        check("len0_clear", pl_status, 32'h0);
        ctrl(2'd1, 16'(NW + 1), 1'b1);
        wait_done(20);
        check("len513_status", pl_status, 32'h0000_0005);
        ctrl(2'd1, 16'(NW + 1), 1'b0);
        @(negedge clk);
        check("len513_clear", pl_status, 32'h0);
        check("lenerr_nowrites", 32'(we_total - we_snap), 32'd0);

        // Handshake: start held after done, then re-armed with mul
        mem_a[0] = 32'h0002_0003; mem_b[0] = 32'h0005_0006;
        mem_a[1] = 32'h0004_FFFF; mem_b[1] = 32'h0003_0002;
        ctrl(2'd1, 16'd2, 1'b1);
        wait_done(100);
        we_snap = we_total;
        repeat (10) @(negedge clk);
        check("hold_no_rerun", 32'(we_total - we_snap), 32'd0);
        check("hold_status", pl_status, 32'h0002_0001);
        check("hs_add_w1", mem_p[1], 32'h0007_0001);
        ctrl(2'd1, 16'd2, 1'b0);
        @(negedge clk);
        check("hs_done_clr", pl_status, 32'h0002_0000);
        ctrl(2'd0, 16'd2, 1'b1);
        @(negedge clk);
        check("hs_restart_cnt", pl_status, 32'h0000_0002);
        wait_done(100);
        check("hs_mul_w0", mem_p[0], 32'h000A_0012);
        check("hs_mul_w1", mem_p[1], 32'h000C_FFFE);
        check("hs_mul_status", pl_status, 32'h0002_0001);
        ctrl(2'd0, 16'd2, 1'b0);
        @(negedge clk);

        // Control changes mid-run are ignored
        for (int i = 0; i < 6; i++) begin
            mem_a[i] = {16'(i), 16'(i)};
            mem_b[i] = 32'h0001_0001;
        end
        we_snap = we_total;
        ctrl(2'd1, 16'd6, 1'b1);
        @(negedge clk);
        ctrl(2'd0, 16'd1, 1'b0);
        @(negedge clk);
        ctrl(2'd2, 16'd1, 1'b1);
        wait_done(100);
        check("mid_nwrites", 32'(we_total - we_snap), 32'd6);
        check("mid_status", pl_status, 32'h0006_0001);
        check("mid_w0", mem_p[0], 32'h0001_0001);
        check("mid_w5", mem_p[5], 32'h0006_0006);
        ctrl(2'd2, 16'd1, 1'b0);
        @(negedge clk);

        // Async reset mid-run
        ctrl(2'd1, 16'd8, 1'b1);
        repeat (3) @(negedge clk);
        #2;
        reset      = 1'b0;
        ps_control = 32'h0;
        #1;
        check("arst_status", pl_status, 32'h0);
        check("arst_we", {28'd0, bram_we_product}, 32'h0);
        check("arst_addr_a", {20'd0, bram_addr_a}, 32'h0);
        check("arst_addr_p", {20'd0, bram_addr_product}, 32'h0);
        check("arst_wrdata", bram_wrdata_product, 32'h0);
        we_snap = we_total;
        repeat (4) @(negedge clk);
        check("arst_nowrites", 32'(we_total - we_snap), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        mem_a[0] = 32'h1234_0001; mem_b[0] = 32'h0001_0001;
        mem_a[1] = 32'h7FFF_8000; mem_b[1] = 32'h0001_FFFF;
        ctrl(2'd1, 16'd2, 1'b1);
        wait_done(100);
        check("post_rst_status", pl_status, 32'h0002_0001);
        check("post_rst_w0", mem_p[0], 32'h1235_0002);
        check("post_rst_w1", mem_p[1], 32'h8000_7FFF);
        ctrl(2'd1, 16'd2, 1'b0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
